// File: rtl/length_pkg.sv
// Shared definitions for the length-counter bank: defaults, length table and index decode.
// Purely combinational helpers; no state or backpressure.
package length_pkg;

    localparam int LC_NUM_CH_DEF       = 4;
    localparam int LC_CNT_W_DEF        = 8;
    localparam int LC_IDX_W_DEF        = 5;
    localparam int LC_TABLE_MODE_DEF   = 0;
    localparam int LC_RELOAD_QUIRK_DEF = 1;

    localparam int LC_LOOKUP_W = 32;

    typedef enum logic {
        LC_MODE_NES    = 1'b0,
        LC_MODE_LINEAR = 1'b1
    } lc_mode_e;

    localparam logic [7:0] LC_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    // Result is wide enough for any legal CNT_W; callers truncate to their counter width.
    function automatic logic [LC_LOOKUP_W-1:0] lc_lookup(
        input logic [LC_LOOKUP_W-1:0] idx,
        input lc_mode_e               mode
    );
        if (mode == LC_MODE_LINEAR) begin
            return idx + LC_LOOKUP_W'(1);
        end
        return {24'b0, LC_TABLE[idx[4:0]]};
    endfunction

endpackage

// File: rtl/length_chan.sv
// One length-counter channel: enable bit, halt pipeline, counter and priority update.
// Latency: state updates on the clock edge, status is combinational from the counter.
module length_chan
    import length_pkg::*;
#(
    parameter int CNT_W        = LC_CNT_W_DEF,
    parameter int RELOAD_QUIRK = LC_RELOAD_QUIRK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_en,
    input  logic             en_din,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             halt,
    input  logic             half_tick,
    output logic [CNT_W-1:0] cnt,
    output logic             status
);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
    logic             en_q, en_d;
    logic             halt_q, halt_d;
    logic             load_ok, tick_ok;

    always_comb begin
        en_d    = w_en ? en_din : en_q;
        halt_d  = halt;
        // Load qualification uses the enable as it stood before this edge.
        load_ok = load & en_q;
        tick_ok = half_tick & ~halt_q & (cnt_q != '0);
        cnt_dec = tick_ok ? cnt_q - CNT_W'(1) : cnt_q;
        cnt_d   = cnt_dec;
        if (w_en && !en_din) begin
            cnt_d = '0;
        end else if (load_ok) begin
            if (half_tick && (RELOAD_QUIRK != 0) && (cnt_q != '0)) begin
                cnt_d = cnt_dec;
            end else begin
                cnt_d = load_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            halt_q <= halt_d;
        end
    end

    assign cnt    = cnt_q;
    assign status = (cnt_q != '0);

endmodule

// File: rtl/length_counter_bank.sv
// Bank of NUM_CH length counters sharing one table-decoded load index and half-frame tick.
// Latency: outputs reflect each edge's update immediately after it; no backpressure.
module length_counter_bank
    import length_pkg::*;
#(
    parameter int NUM_CH       = LC_NUM_CH_DEF,
    parameter int CNT_W        = LC_CNT_W_DEF,
    parameter int IDX_W        = LC_IDX_W_DEF,
    parameter int TABLE_MODE   = LC_TABLE_MODE_DEF,
    parameter int RELOAD_QUIRK = LC_RELOAD_QUIRK_DEF
) (
    input  logic                    ACLK1,
    input  logic                    n_RES,
    input  logic                    W_EN,
    input  logic [NUM_CH-1:0]       EN_DIN,
    input  logic [NUM_CH-1:0]       LOAD,
    input  logic [IDX_W-1:0]        LOAD_IDX,
    input  logic [NUM_CH-1:0]       HALT,
    input  logic                    HALF_TICK,
    output logic [NUM_CH-1:0]       STATUS,
    output logic [NUM_CH-1:0]       NOTCOUNT,
    output logic [NUM_CH*CNT_W-1:0] COUNT
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("length_counter_bank: NUM_CH must be 1..16");
    end
    if (TABLE_MODE != 0 && TABLE_MODE != 1) begin : g_bad_mode
        $error("length_counter_bank: TABLE_MODE must be 0 or 1");
    end
    if (RELOAD_QUIRK != 0 && RELOAD_QUIRK != 1) begin : g_bad_quirk
        $error("length_counter_bank: RELOAD_QUIRK must be 0 or 1");
    end
    if (TABLE_MODE == 0 && (CNT_W < 8 || IDX_W != 5)) begin : g_bad_nes
        $error("length_counter_bank: NES table needs CNT_W>=8 and IDX_W==5");
    end
    if (CNT_W < 1 || CNT_W > LC_LOOKUP_W || IDX_W < 1 || IDX_W > 31) begin : g_bad_width
        $error("length_counter_bank: CNT_W must be 1..32 and IDX_W 1..31");
    end

    localparam lc_mode_e MODE = (TABLE_MODE == 1) ? LC_MODE_LINEAR : LC_MODE_NES;

    // Decoded once and fanned out to every channel.
    logic [CNT_W-1:0] load_val;
    assign load_val = CNT_W'(lc_lookup(LC_LOOKUP_W'(LOAD_IDX), MODE));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        length_chan #(
            .CNT_W        (CNT_W),
            .RELOAD_QUIRK (RELOAD_QUIRK)
        ) u_chan (
            .clk       (ACLK1),
            .rst_n     (n_RES),
            .w_en      (W_EN),
            .en_din    (EN_DIN[i]),
            .load      (LOAD[i]),
            .load_val  (load_val),
            .halt      (HALT[i]),
            .half_tick (HALF_TICK),
            .cnt       (COUNT[i*CNT_W +: CNT_W]),
            .status    (STATUS[i])
        );
    end

    assign NOTCOUNT = ~STATUS;

endmodule

// File: tb/tb_length_counter_bank.sv
// Bench for length_counter_bank: three builds (default, load-wins, 6ch linear) on shared stimulus.
module tb_length_counter_bank;

    logic       ACLK1 = 1'b0;
    logic       n_RES;
    logic       w_en;
    logic [5:0] en_din, load, halt;
    logic [4:0] load_idx;
    logic       tick;

    logic [31:0] cnt0, cnt1;
    logic [59:0] cnt2;
    logic [3:0]  st0, st1, nc0, nc1;
    logic [5:0]  st2, nc2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK1 = ~ACLK1;

    length_counter_bank u_dut0 (
        .ACLK1(ACLK1), .n_RES(n_RES), .W_EN(w_en), .EN_DIN(en_din[3:0]), .LOAD(load[3:0]),
        .LOAD_IDX(load_idx), .HALT(halt[3:0]), .HALF_TICK(tick),
        .STATUS(st0), .NOTCOUNT(nc0), .COUNT(cnt0)
    );

    length_counter_bank #(.RELOAD_QUIRK(0)) u_dut1 (
        .ACLK1(ACLK1), .n_RES(n_RES), .W_EN(w_en), .EN_DIN(en_din[3:0]), .LOAD(load[3:0]),
        .LOAD_IDX(load_idx), .HALT(halt[3:0]), .HALF_TICK(tick),
        .STATUS(st1), .NOTCOUNT(nc1), .COUNT(cnt1)
    );

    length_counter_bank #(.NUM_CH(6), .CNT_W(10), .TABLE_MODE(1)) u_dut2 (
        .ACLK1(ACLK1), .n_RES(n_RES), .W_EN(w_en), .EN_DIN(en_din), .LOAD(load),
        .LOAD_IDX(load_idx), .HALT(halt), .HALF_TICK(tick),
        .STATUS(st2), .NOTCOUNT(nc2), .COUNT(cnt2)
    );

    // Reference model: per build, per channel counter / enable / delayed halt as plain integers.
    int NCH   [3] = '{4, 4, 6};
    int CW    [3] = '{8, 8, 10};
    int MODE  [3] = '{0, 0, 1};
    int QUIRK [3] = '{1, 0, 1};
    int NES   [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
    int m_cnt [3][6];
    int m_en  [3][6];
    int m_hq  [3][6];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 6; i++) begin
                m_cnt[c][i] = 0;
                m_en[c][i]  = 0;
                m_hq[c][i]  = 0;
            end
    endtask

    function automatic int table_val(input int c, input int idx);
        return (MODE[c] == 1) ? idx + 1 : NES[idx];
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < NCH[c]; i++) begin
                int cur  = m_cnt[c][i];
                int dec  = (tick && m_hq[c][i] == 0 && cur > 0) ? cur - 1 : cur;
                int nxt  = dec;
                bit ldok = load[i] && (m_en[c][i] == 1);
                if (w_en && !en_din[i])          nxt = 0;
                else if (ldok && tick)           nxt = (cur == 0 || QUIRK[c] == 0) ? table_val(c, int'(load_idx)) : dec;
                else if (ldok)                   nxt = table_val(c, int'(load_idx));
                m_cnt[c][i] = nxt;
                if (w_en) m_en[c][i] = int'(en_din[i]);
                m_hq[c][i] = int'(halt[i]);
            end
    endtask

    function automatic logic [63:0] exp_count(input int c);
        logic [63:0] e = '0;
        for (int i = 0; i < NCH[c]; i++) e |= 64'(m_cnt[c][i]) << (i * CW[c]);
        return e;
    endfunction

    function automatic logic [63:0] exp_status(input int c);
        logic [63:0] e = '0;
        for (int i = 0; i < NCH[c]; i++) e[i] = (m_cnt[c][i] != 0);
        return e;
    endfunction

    task automatic compare_all();
        check("d0_count", 64'(cnt0), exp_count(0));
        check("d0_status", 64'(st0), exp_status(0));
        check("d0_notcount", 64'(nc0), exp_status(0) ^ 64'hF);
        check("d1_count", 64'(cnt1), exp_count(1));
        check("d1_status", 64'(st1), exp_status(1));
        check("d1_notcount", 64'(nc1), exp_status(1) ^ 64'hF);
        check("d2_count", 64'(cnt2), exp_count(2));
        check("d2_status", 64'(st2), exp_status(2));
        check("d2_notcount", 64'(nc2), exp_status(2) ^ 64'h3F);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge ACLK1);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        w_en = 1'b0;
        load = '0;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    initial begin
        n_RES = 1'b0; w_en = 1'b0; en_din = '0; load = '0; load_idx = '0; halt = '0; tick = 1'b0;
        model_reset();
        #1;
        compare_all();
        #12 n_RES = 1'b1;
        cyc();

        // Basic load, partial count-down, then asynchronous reset with no edge.
        w_en = 1'b1; en_din = 6'b000001; cyc(); idle();
        load = 6'b000001; load_idx = 5'd1; cyc(); idle();
        check("ld254", 64'(cnt0[7:0]), 64'd254);
        check("ld254_st", 64'(st0[0]), 64'd1);
        ticks(154);
        check("cnt100", 64'(cnt0[7:0]), 64'd100);
        n_RES = 1'b0;
        #1;
        check("arst_cnt", 64'(cnt0), 64'd0);
        check("arst_st", 64'(st0), 64'd0);
        check("arst_nc", 64'(nc0), 64'hF);
        model_reset();
        compare_all();
        #1 n_RES = 1'b1;

        // Full count-down and saturation at zero.
        w_en = 1'b1; en_din = 6'b000001; cyc(); idle();
        load = 6'b000001; load_idx = 5'd1; cyc(); idle();
        ticks(254);
        check("drain", 64'(cnt0[7:0]), 64'd0);
        check("drain_nc", 64'(nc0[0]), 64'd1);
        ticks(3);
        check("sat0", 64'(cnt0[7:0]), 64'd0);

        // Disabled channel ignores load; disable wins over a tick.
        load = 6'b000010; load_idx = 5'd0; cyc(); idle();
        check("dis_ld", 64'(cnt0[15:8]), 64'd0);
        w_en = 1'b1; en_din = 6'b000011; cyc(); idle();
        load = 6'b000010; load_idx = 5'd8; cyc(); idle();
        check("ld160", 64'(cnt0[15:8]), 64'd160);
        w_en = 1'b1; en_din = 6'b000001; tick = 1'b1; cyc(); idle();
        check("dis_clr", 64'(cnt0[15:8]), 64'd0);

        // Reload/tick collision on non-zero (ch0) and zero (ch2) counters.
        w_en = 1'b1; en_din = 6'b000111; cyc(); idle();
        load = 6'b000001; load_idx = 5'd0; cyc(); idle();
        ticks(5);
        check("pre5", 64'(cnt0[7:0]), 64'd5);
        load = 6'b000101; load_idx = 5'd3; tick = 1'b1; cyc(); idle();
        check("quirk_drop", 64'(cnt0[7:0]), 64'd4);
        check("quirk_zero", 64'(cnt0[23:16]), 64'd2);
        check("noquirk", 64'(cnt1[7:0]), 64'd2);

        // Halt is honoured one edge late.
        load = 6'b000001; load_idx = 5'd0; cyc(); idle();
        halt = 6'b000001; tick = 1'b1; cyc();
        check("halt_rise", 64'(cnt0[7:0]), 64'd9);
        cyc();
        check("halt_hold", 64'(cnt0[7:0]), 64'd9);
        halt = 6'b000000; cyc();
        check("halt_fall", 64'(cnt0[7:0]), 64'd9);
        cyc(); idle();
        check("halt_resume", 64'(cnt0[7:0]), 64'd8);

        // Parametrised build: linear table, all channels ticking together.
        w_en = 1'b1; en_din = 6'b111111; cyc(); idle();
        load = 6'b100000; load_idx = 5'd31; cyc(); idle();
        check("lin32", 64'(cnt2[59:50]), 64'd32);
        load = 6'b011111; load_idx = 5'd4; cyc(); idle();
        ticks(3);
        check("lin_all", 64'(cnt2[9:0]), 64'd2);
        check("lin_ch5", 64'(cnt2[59:50]), 64'd29);

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            w_en     = ($urandom_range(0, 15) == 0);
            en_din   = 6'($urandom);
            load     = 6'($urandom & $urandom);
            load_idx = 5'($urandom);
            tick     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) halt = 6'($urandom);
            cyc();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
